// File: rtl/display_pkg.sv
// Shared types and helpers for the multiplexed 7-segment scan controller.
package display_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DEAD
  } scan_state_t;

  localparam logic [6:0] BLANK_CODE = 7'h7F;

  // A visible digit keeps its upper 3 bits at zero, so it can never alias BLANK_CODE.
  function automatic logic [6:0] digit_code(input logic [3:0] nibble, input logic blank,
                                            input logic blink, input logic phase);
    if (blank || (blink && phase)) return BLANK_CODE;
    return {3'b000, nibble};
  endfunction

endpackage

// File: rtl/scan_timer.sv
// Cycle counter shared by the lit slot and the dead gap; strobes on the last cycle of each.
module scan_timer #(
  parameter int REFRESH_DIV = 50000,
  parameter int DEAD_CYCLES = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear,
  input  logic dead,
  output logic slot_end,
  output logic dead_end
);

  localparam int MAX_COUNT = (REFRESH_DIV > DEAD_CYCLES) ? REFRESH_DIV : DEAD_CYCLES;
  localparam int CNT_W     = $clog2(MAX_COUNT);

  logic [CNT_W-1:0] cnt_reg;

  assign slot_end = !dead && (cnt_reg == CNT_W'(REFRESH_DIV - 1));
  assign dead_end = dead && (cnt_reg == CNT_W'(DEAD_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!resetn || clear) begin
      cnt_reg <= '0;
    end else if (slot_end || dead_end) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Scans NUM_DIGITS common-anode digits through one shared hex decoder, with a
// double-buffered image committed only at frame boundaries, blanking, blink and dead time.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int DEAD_CYCLES  = 2,
  parameter int BLINK_FRAMES = 32
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    enable,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] load_digits,
  input  logic [NUM_DIGITS-1:0]   load_blank,
  input  logic [NUM_DIGITS-1:0]   load_blink,
  output logic [6:0]              dec_code,
  output logic [NUM_DIGITS-1:0]   dig_sel_n,
  output logic                    frame_done
);

  localparam int IDX_W   = $clog2(NUM_DIGITS);
  localparam int FRAME_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  scan_state_t state_reg, state_next;
  logic [IDX_W-1:0] idx_reg, idx_next;

  logic [4*NUM_DIGITS-1:0] act_digits_reg, act_digits_next;
  logic [NUM_DIGITS-1:0]   act_blank_reg, act_blank_next;
  logic [NUM_DIGITS-1:0]   act_blink_reg, act_blink_next;
  logic [4*NUM_DIGITS-1:0] shd_digits_reg;
  logic [NUM_DIGITS-1:0]   shd_blank_reg;
  logic [NUM_DIGITS-1:0]   shd_blink_reg;
  logic                    pending_reg, pending_next;

  logic [FRAME_W-1:0] frame_cnt_reg, frame_cnt_next;
  logic               phase_reg, phase_next;

  logic [6:0]            code_reg, code_next;
  logic [NUM_DIGITS-1:0] sel_reg, sel_next;
  logic                  frame_done_reg;
  logic                  ready_reg;

  logic frame_end, accept, commit;
  logic timer_clear, in_dead, slot_end, dead_end;
  logic [3:0] nib_next [NUM_DIGITS];

  assign in_dead     = (state_reg == DEAD);
  assign timer_clear = (state_reg == IDLE) || !enable;

  scan_timer #(
    .REFRESH_DIV(REFRESH_DIV),
    .DEAD_CYCLES(DEAD_CYCLES)
  ) u_scan_timer (
    .clk     (clk),
    .resetn  (resetn),
    .clear   (timer_clear),
    .dead    (in_dead),
    .slot_end(slot_end),
    .dead_end(dead_end)
  );

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    frame_end  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (enable) begin
          state_next = SCAN;
          idx_next   = '0;
        end
      end
      SCAN: begin
        if (!enable) begin
          state_next = IDLE;
          idx_next   = '0;
        end else if (slot_end) begin
          state_next = DEAD;
        end
      end
      DEAD: begin
        if (!enable) begin
          state_next = IDLE;
          idx_next   = '0;
        end else if (dead_end) begin
          state_next = SCAN;
          if (idx_reg == IDX_W'(NUM_DIGITS - 1)) begin
            idx_next  = '0;
            frame_end = 1'b1;
          end else begin
            idx_next = idx_reg + 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
        idx_next   = '0;
      end
    endcase
  end

  // Ready is low whenever something is pending, so accept and commit never overlap.
  always_comb begin
    accept          = load_valid && ready_reg;
    commit          = pending_reg && (frame_end || (state_reg == IDLE));
    pending_next    = accept || (pending_reg && !commit);
    act_digits_next = commit ? shd_digits_reg : act_digits_reg;
    act_blank_next  = commit ? shd_blank_reg  : act_blank_reg;
    act_blink_next  = commit ? shd_blink_reg  : act_blink_reg;
  end

  always_comb begin
    frame_cnt_next = frame_cnt_reg;
    phase_next     = phase_reg;
    if (state_next == IDLE) begin
      frame_cnt_next = '0;
    end else if (frame_end) begin
      if (frame_cnt_reg == FRAME_W'(BLINK_FRAMES - 1)) begin
        frame_cnt_next = '0;
        phase_next     = !phase_reg;
      end else begin
        frame_cnt_next = frame_cnt_reg + 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_nib
    assign nib_next[gi] = act_digits_next[4*gi +: 4];
  end

  // Outputs are built from next-state values so the registered pins track the state register.
  always_comb begin
    code_next = BLANK_CODE;
    sel_next  = '1;
    if (state_next == SCAN) begin
      sel_next[idx_next] = 1'b0;
      code_next = digit_code(nib_next[idx_next], act_blank_next[idx_next],
                             act_blink_next[idx_next], phase_next);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg      <= IDLE;
      idx_reg        <= '0;
      act_digits_reg <= '0;
      act_blank_reg  <= '1;
      act_blink_reg  <= '0;
      shd_digits_reg <= '0;
      shd_blank_reg  <= '0;
      shd_blink_reg  <= '0;
      pending_reg    <= 1'b0;
      frame_cnt_reg  <= '0;
      phase_reg      <= 1'b0;
      code_reg       <= BLANK_CODE;
      sel_reg        <= '1;
      frame_done_reg <= 1'b0;
      ready_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      idx_reg        <= idx_next;
      act_digits_reg <= act_digits_next;
      act_blank_reg  <= act_blank_next;
      act_blink_reg  <= act_blink_next;
      if (accept) begin
        shd_digits_reg <= load_digits;
        shd_blank_reg  <= load_blank;
        shd_blink_reg  <= load_blink;
      end
      pending_reg    <= pending_next;
      frame_cnt_reg  <= frame_cnt_next;
      phase_reg      <= phase_next;
      code_reg       <= code_next;
      sel_reg        <= sel_next;
      frame_done_reg <= frame_end;
      ready_reg      <= !pending_next;
    end
  end

  assign dec_code   = code_reg;
  assign dig_sel_n  = sel_reg;
  assign frame_done = frame_done_reg;
  assign load_ready = ready_reg;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench: scan order, image commit timing, handshake hold-off, blink and reset/enable abort.
module tb_display_scan_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        enable;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] load_digits;
  logic [3:0]  load_blank;
  logic [3:0]  load_blink;
  logic [6:0]  dec_code;
  logic [3:0]  dig_sel_n;
  logic        frame_done;

  int vecs = 0;
  int errs = 0;

  display_scan_ctrl #(
    .NUM_DIGITS  (4),
    .REFRESH_DIV (4),
    .DEAD_CYCLES (1),
    .BLINK_FRAMES(2)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .enable     (enable),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_digits(load_digits),
    .load_blank (load_blank),
    .load_blink (load_blink),
    .dec_code   (dec_code),
    .dig_sel_n  (dig_sel_n),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vecs++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Frame cycle c: slot c/5, cycles 0..3 lit, cycle 4 dead gap.
  task automatic check_span(input logic [15:0] digs, input logic [3:0] blk, input logic [3:0] hid,
                            input bit fd_first, input int first, input int last);
    int d;
    bit dead;
    logic [3:0] es;
    logic [6:0] ec;
    logic [3:0] nib;
    for (int c = first; c <= last; c++) begin
      @(negedge clk);
      d    = c / 5;
      dead = ((c % 5) == 4);
      nib  = digs[4*d +: 4];
      es   = dead ? 4'hF : ~(4'b0001 << d);
      ec   = (dead || blk[d] || hid[d]) ? 7'h7F : {3'b000, nib};
      check($sformatf("sel c=%0d", c), {12'h0, dig_sel_n}, {12'h0, es});
      check($sformatf("code c=%0d", c), {9'h0, dec_code}, {9'h0, ec});
      check($sformatf("frame_done c=%0d", c), {15'h0, frame_done}, {15'h0, (fd_first && c == 0)});
    end
  endtask

  // Drop enable, load an image while idle, then re-enable; called on a negedge.
  task automatic load_idle(input logic [15:0] digs, input logic [3:0] blk, input logic [3:0] bl);
    enable = 1'b0;
    @(negedge clk);
    check("idle sel", {12'h0, dig_sel_n}, 16'h000F);
    check("idle code", {9'h0, dec_code}, 16'h007F);
    check("idle frame_done", {15'h0, frame_done}, 16'h0000);
    check("idle ready", {15'h0, load_ready}, 16'h0001);
    load_valid  = 1'b1;
    load_digits = digs;
    load_blank  = blk;
    load_blink  = bl;
    @(negedge clk);
    check("accept ready", {15'h0, load_ready}, 16'h0000);
    load_valid = 1'b0;
    @(negedge clk);
    check("idle commit ready", {15'h0, load_ready}, 16'h0001);
    check("idle commit code", {9'h0, dec_code}, 16'h007F);
    $display("load idle digits=%h blank=%b blink=%b", digs, blk, bl);
    enable = 1'b1;
  endtask

  initial begin
    resetn      = 1'b0;
    enable      = 1'b0;
    load_valid  = 1'b0;
    load_digits = 16'h0;
    load_blank  = 4'h0;
    load_blink  = 4'h0;
    repeat (3) @(negedge clk);
    check("rst sel", {12'h0, dig_sel_n}, 16'h000F);
    check("rst code", {9'h0, dec_code}, 16'h007F);
    check("rst frame_done", {15'h0, frame_done}, 16'h0000);
    check("rst ready", {15'h0, load_ready}, 16'h0000);

    // Blank image scanned straight out of reset.
    resetn = 1'b1;
    enable = 1'b1;
    check_span(16'h0, 4'hF, 4'h0, 1'b0, 0, 0);
    check("release ready", {15'h0, load_ready}, 16'h0001);
    check_span(16'h0, 4'hF, 4'h0, 1'b0, 1, 19);
    check_span(16'h0, 4'hF, 4'h0, 1'b1, 0, 19);

    load_idle(16'h1A3F, 4'h0, 4'h0);
    check_span(16'h1A3F, 4'h0, 4'h0, 1'b0, 0, 19);

    // Mid-frame load waits for the frame boundary; a second offer is held off.
    load_idle(16'h1111, 4'h0, 4'h0);
    check_span(16'h1111, 4'h0, 4'h0, 1'b0, 0, 6);
    load_valid  = 1'b1;
    load_digits = 16'h2222;
    check_span(16'h1111, 4'h0, 4'h0, 1'b0, 7, 7);
    check("pending ready", {15'h0, load_ready}, 16'h0000);
    $display("load accepted digits=2222 mid-frame");
    load_digits = 16'h3333;
    check_span(16'h1111, 4'h0, 4'h0, 1'b0, 8, 19);
    check("pending ready end", {15'h0, load_ready}, 16'h0000);
    check_span(16'h2222, 4'h0, 4'h0, 1'b1, 0, 0);
    check("ready after commit", {15'h0, load_ready}, 16'h0001);
    check_span(16'h2222, 4'h0, 4'h0, 1'b0, 1, 1);
    check("second accept ready", {15'h0, load_ready}, 16'h0000);
    $display("load accepted digits=3333 after hold-off");
    load_valid = 1'b0;
    check_span(16'h2222, 4'h0, 4'h0, 1'b0, 2, 19);
    check_span(16'h3333, 4'h0, 4'h0, 1'b1, 0, 19);
    check("ready idle", {15'h0, load_ready}, 16'h0001);

    // Blink on digit 0; phase is 1 here, toggling every 2 frames.
    load_idle(16'h4321, 4'h0, 4'b0001);
    check_span(16'h4321, 4'h0, 4'b0001, 1'b0, 0, 19);
    check_span(16'h4321, 4'h0, 4'b0001, 1'b1, 0, 19);
    check_span(16'h4321, 4'h0, 4'b0000, 1'b1, 0, 19);
    check_span(16'h4321, 4'h0, 4'b0000, 1'b1, 0, 19);
    check_span(16'h4321, 4'h0, 4'b0001, 1'b1, 0, 19);
    check_span(16'h4321, 4'h0, 4'b0001, 1'b1, 0, 2);

    // Enable drop mid-slot, restart, then reset mid-frame.
    enable = 1'b0;
    @(negedge clk);
    check("abort sel", {12'h0, dig_sel_n}, 16'h000F);
    check("abort code", {9'h0, dec_code}, 16'h007F);
    check("abort frame_done", {15'h0, frame_done}, 16'h0000);
    enable = 1'b1;
    check_span(16'h4321, 4'h0, 4'b0001, 1'b0, 0, 8);
    resetn = 1'b0;
    @(negedge clk);
    check("mid rst sel", {12'h0, dig_sel_n}, 16'h000F);
    check("mid rst code", {9'h0, dec_code}, 16'h007F);
    check("mid rst frame_done", {15'h0, frame_done}, 16'h0000);
    check("mid rst ready", {15'h0, load_ready}, 16'h0000);
    resetn = 1'b1;
    check_span(16'h0, 4'hF, 4'h0, 1'b0, 0, 0);
    check("re-release ready", {15'h0, load_ready}, 16'h0001);
    check_span(16'h0, 4'hF, 4'h0, 1'b0, 1, 19);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
